// File: rtl/feeder_pkg.sv
// Shared types for the stream operand feeder: FSM state encoding and counter width helper.
package feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/feeder_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags; holds DUT results for the consumer.
module feeder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is refused even if a pop happens in the same cycle.
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_operand_feeder.sv
// Preloaded operand pairs streamed cyclically to an arithmetic DUT, results buffered in a FIFO.
// Optional stall counter port enabled by defining STREAM_OPERAND_FEEDER_STALL_CNT_EN.
module stream_operand_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LENGTH    = 2000,
  parameter int RES_DEPTH = 8,
  localparam int CW       = cnt_width(LENGTH)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_a_i,
  input  logic [WIDTH-1:0] load_b_i,
  output logic             op_valid_o,
  input  logic             op_ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [WIDTH-1:0] res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    sent_cnt_o,
  output logic [CW-1:0]    recv_cnt_o
`ifdef STREAM_OPERAND_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam int LW = cnt_width(DEPTH);
  localparam int IW = $clog2(DEPTH);

  feeder_state_e    state, state_nxt;
  logic [WIDTH-1:0] op_a_mem [DEPTH];
  logic [WIDTH-1:0] op_b_mem [DEPTH];
  logic [LW-1:0]    load_cnt;
  logic [IW-1:0]    rd_idx;
  logic [CW-1:0]    sent_cnt;
  logic [CW-1:0]    recv_cnt;
  logic             load_fire;
  logic             op_fire;
  logic             start_run;
  logic             res_push;
  logic             fifo_full;
  logic             fifo_empty;

  assign load_ready_o = (state == ST_IDLE) && (load_cnt != LW'(DEPTH));
  assign load_fire    = load_valid_i && load_ready_o;
  assign op_valid_o   = (state == ST_SEND);
  assign op_fire      = op_valid_o && op_ready_i;
  assign start_run    = start_i && (((state == ST_IDLE) && (load_cnt != '0)) || (state == ST_DONE));
  assign a_o          = op_valid_o ? op_a_mem[rd_idx] : '0;
  assign b_o          = op_valid_o ? op_b_mem[rd_idx] : '0;
  assign busy_o       = (state == ST_SEND) || (state == ST_DRAIN);
  assign done_o       = (state == ST_DONE);
  assign sent_cnt_o   = sent_cnt;
  assign recv_cnt_o   = recv_cnt;
  assign res_ready_o  = !fifo_full;
  assign out_valid_o  = !fifo_empty;
  // Results outside a run, or beyond LENGTH, are dropped without being counted.
  assign res_push     = res_valid_i && res_ready_o && busy_o && (recv_cnt != CW'(LENGTH));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_run) state_nxt = ST_SEND;
      ST_SEND:  if (op_fire && (sent_cnt == CW'(LENGTH - 1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if (recv_cnt == CW'(LENGTH)) state_nxt = ST_DONE;
      ST_DONE:  if (start_run) state_nxt = ST_SEND;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Buffer contents are not reset; load_cnt alone marks how many entries are valid.
  always_ff @(posedge clk_i) begin
    if (load_fire) begin
      op_a_mem[load_cnt[IW-1:0]] <= load_a_i;
      op_b_mem[load_cnt[IW-1:0]] <= load_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      load_cnt <= '0;
      rd_idx   <= '0;
      sent_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      if (load_fire) load_cnt <= load_cnt + LW'(1);
      if (start_run) begin
        rd_idx   <= '0;
        sent_cnt <= '0;
        recv_cnt <= '0;
      end else begin
        if (op_fire) begin
          sent_cnt <= sent_cnt + CW'(1);
          rd_idx   <= (LW'(rd_idx) == load_cnt - LW'(1)) ? '0 : rd_idx + IW'(1);
        end
        if (res_push) recv_cnt <= recv_cnt + CW'(1);
      end
    end
  end

`ifdef STREAM_OPERAND_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                        stall_cnt_o <= '0;
    else if (start_i)                                     stall_cnt_o <= '0;
    else if (op_valid_o && !op_ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

  feeder_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (res_push),
    .data_i   (res_i),
    .pop_i    (out_ready_i),
    .data_o   (out_data_o),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule
